ahb_dma_engine: RTL and testbench



---
 rtl/ahb_pkg.sv | 28 ++
 rtl/ahb_dma_engine.sv | 178 +++++++++++++++++
 tb/tb_ahb_dma_engine.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings for every initiator and responder on the SoC bus
// (cpu_core, ahb_dma_engine, slaves).
//   htrans_e       : HTRANS transfer type encodings
//   HSIZE_WORD     : 32-bit transfer size
//   HBURST_SINGLE  : single (non-burst) transfer
//   HPROT_DEFAULT  : data access, privileged, non-bufferable, non-cacheable
//   word_align()   : clears the byte-offset bits of a byte address
// ---------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ahb_dma_engine.sv
// ---------------------------------------------------------------------------
// ahb_dma_engine
// Word-copy DMA engine, AHB-Lite initiator. Accepts one copy command at a
// time and moves it with single non-pipelined read/write transfers
// (read word, write word, repeat).
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   cmd_valid / cmd_ready    command handshake (ready only while idle)
//   cmd_src, cmd_dst         byte addresses, low two bits ignored
//   cmd_len                  number of 32-bit words (0 = no bus activity)
//   busy                     command in progress (complement of cmd_ready)
//   done, err                one-cycle completion pulse, err valid with it
//   ahb_*_o                  AHB-Lite initiator address/control/write data
//   ahb_hready_i/hresp_i/hrdata_i  responder returns
// ---------------------------------------------------------------------------
module ahb_dma_engine
  import ahb_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      ahb_haddr_o,
  output logic             ahb_hwrite_o,
  output logic [2:0]       ahb_hsize_o,
  output logic [2:0]       ahb_hburst_o,
  output logic [3:0]       ahb_hprot_o,
  output logic [1:0]       ahb_htrans_o,
  output logic             ahb_hmastlock_o,
  output logic [31:0]      ahb_hwdata_o,
  input  logic             ahb_hready_i,
  input  logic             ahb_hresp_i,
  input  logic [31:0]      ahb_hrdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_FINISH
  } state_e;

  state_e           state_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] len_q;
  logic [31:0]      data_q;
  logic [31:0]      haddr_q;
  htrans_e          htrans_q;
  logic             hwrite_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  // All bus and status outputs are updated together with the state so that
  // they change only on the clock edge that moves the FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      data_q   <= '0;
      haddr_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            src_q  <= word_align(cmd_src);
            dst_q  <= word_align(cmd_dst);
            len_q  <= cmd_len;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            if (cmd_len == '0) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_RD_ADDR;
              haddr_q  <= word_align(cmd_src);
              htrans_q <= HTRANS_NONSEQ;
              hwrite_q <= 1'b0;
            end
          end
        end
        S_RD_ADDR: begin
          if (ahb_hready_i) begin
            state_q  <= S_RD_DATA;
            htrans_q <= HTRANS_IDLE;
          end
        end
        S_RD_DATA: begin
          // hresp is only meaningful on the completing (hready=1) cycle; the
          // first cycle of a two-cycle error simply stalls here.
          if (ahb_hready_i) begin
            if (ahb_hresp_i) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              data_q   <= ahb_hrdata_i;
              state_q  <= S_WR_ADDR;
              haddr_q  <= dst_q;
              htrans_q <= HTRANS_NONSEQ;
              hwrite_q <= 1'b1;
            end
          end
        end
        S_WR_ADDR: begin
          if (ahb_hready_i) begin
            state_q  <= S_WR_DATA;
            htrans_q <= HTRANS_IDLE;
          end
        end
        S_WR_DATA: begin
          if (ahb_hready_i) begin
            if (ahb_hresp_i) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              // Addresses wrap naturally in 32-bit arithmetic.
              src_q <= src_q + 32'd4;
              dst_q <= dst_q + 32'd4;
              len_q <= len_q - LEN_W'(1);
              if (len_q == LEN_W'(1)) begin
                done_q  <= 1'b1;
                state_q <= S_FINISH;
              end else begin
                state_q  <= S_RD_ADDR;
                haddr_q  <= src_q + 32'd4;
                htrans_q <= HTRANS_NONSEQ;
                hwrite_q <= 1'b0;
              end
            end
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready       = ~busy_q;
  assign busy            = busy_q;
  assign done            = done_q;
  // Sticky until the next command is accepted; qualify with done.
  assign err             = err_q;
  assign ahb_haddr_o     = haddr_q;
  assign ahb_hwrite_o    = hwrite_q;
  assign ahb_htrans_o    = htrans_q;
  // The buffer is only loaded at the end of a read, so it is stable across
  // the whole write address and data phase.
  assign ahb_hwdata_o    = data_q;
  assign ahb_hsize_o     = HSIZE_WORD;
  assign ahb_hburst_o    = HBURST_SINGLE;
  assign ahb_hprot_o     = HPROT_DEFAULT;
  assign ahb_hmastlock_o = 1'b0;

endmodule

// File: tb/tb_ahb_dma_engine.sv
// ---------------------------------------------------------------------------
// tb_ahb_dma_engine
// Drives copy commands into ahb_dma_engine against an AHB-Lite memory
// responder with programmable wait states and error injection, and compares
// bus traffic, copied data, completion latency and status against a
// reference model computed from the transfer rules.
// ---------------------------------------------------------------------------
module tb_ahb_dma_engine;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_src = '0;
  logic [31:0]      cmd_dst = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      ahb_haddr_o;
  logic             ahb_hwrite_o;
  logic [2:0]       ahb_hsize_o;
  logic [2:0]       ahb_hburst_o;
  logic [3:0]       ahb_hprot_o;
  logic [1:0]       ahb_htrans_o;
  logic             ahb_hmastlock_o;
  logic [31:0]      ahb_hwdata_o;
  logic             ahb_hready_i;
  logic             ahb_hresp_i;
  logic [31:0]      ahb_hrdata_i;

  int n_checks = 0;
  int n_errors = 0;

  ahb_dma_engine #(.LEN_W(LEN_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_src        (cmd_src),
    .cmd_dst        (cmd_dst),
    .cmd_len        (cmd_len),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .ahb_haddr_o    (ahb_haddr_o),
    .ahb_hwrite_o   (ahb_hwrite_o),
    .ahb_hsize_o    (ahb_hsize_o),
    .ahb_hburst_o   (ahb_hburst_o),
    .ahb_hprot_o    (ahb_hprot_o),
    .ahb_htrans_o   (ahb_htrans_o),
    .ahb_hmastlock_o(ahb_hmastlock_o),
    .ahb_hwdata_o   (ahb_hwdata_o),
    .ahb_hready_i   (ahb_hready_i),
    .ahb_hresp_i    (ahb_hresp_i),
    .ahb_hrdata_i   (ahb_hrdata_i)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------------------
  // Memory responder. Reads come from src_mem (owned by the stimulus), writes
  // are logged. Each data phase stalls wait_states cycles; an injected error
  // adds the standard two-cycle ERROR response at the end.
  // ------------------------------------------------------------------------
  logic [31:0] src_mem [bit [31:0]];
  logic [31:0] rd_addr_log [$];
  logic [31:0] wr_addr_log [$];
  logic [31:0] wr_data_log [$];
  int wait_states   = 0;
  int rd_err_target = -1;
  int wr_err_target = -1;
  int rd_total      = 0;
  int wr_total      = 0;
  int nonseq_total  = 0;
  int stab_viol     = 0;

  logic        dp_active_q;
  logic        dp_write_q;
  logic        dp_err_q;
  int          dp_cnt_q;
  logic [31:0] dp_addr_q;
  logic [31:0] rdata_q;
  logic        last_stall_q;
  logic [31:0] last_haddr_q;
  logic [31:0] last_hwdata_q;

  assign ahb_hready_i = !dp_active_q || (dp_cnt_q == 0);
  assign ahb_hresp_i  = dp_active_q && dp_err_q && (dp_cnt_q <= 1);
  assign ahb_hrdata_i = rdata_q;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dp_active_q   <= 1'b0;
      dp_write_q    <= 1'b0;
      dp_err_q      <= 1'b0;
      dp_cnt_q      <= 0;
      dp_addr_q     <= '0;
      rdata_q       <= '0;
      last_stall_q  <= 1'b0;
      last_haddr_q  <= '0;
      last_hwdata_q <= '0;
    end else begin
      if (dp_active_q && last_stall_q &&
          (ahb_haddr_o !== last_haddr_q || ahb_hwdata_o !== last_hwdata_q))
        stab_viol <= stab_viol + 1;
      last_stall_q  <= dp_active_q && (dp_cnt_q != 0);
      last_haddr_q  <= ahb_haddr_o;
      last_hwdata_q <= ahb_hwdata_o;
      if (dp_active_q) begin
        if (dp_cnt_q != 0) begin
          dp_cnt_q <= dp_cnt_q - 1;
        end else begin
          dp_active_q <= 1'b0;
          if (dp_write_q && !dp_err_q) begin
            wr_addr_log.push_back(dp_addr_q);
            wr_data_log.push_back(ahb_hwdata_o);
          end
        end
      end
      if (ahb_htrans_o == 2'b10 && ahb_hready_i) begin
        nonseq_total <= nonseq_total + 1;
        dp_active_q  <= 1'b1;
        dp_write_q   <= ahb_hwrite_o;
        dp_addr_q    <= ahb_haddr_o;
        if (ahb_hwrite_o) begin
          dp_err_q <= (wr_total == wr_err_target);
          dp_cnt_q <= wait_states + ((wr_total == wr_err_target) ? 1 : 0);
          wr_total <= wr_total + 1;
        end else begin
          dp_err_q <= (rd_total == rd_err_target);
          dp_cnt_q <= wait_states + ((rd_total == rd_err_target) ? 1 : 0);
          rd_total <= rd_total + 1;
          rd_addr_log.push_back(ahb_haddr_o);
          rdata_q  <= src_mem.exists(ahb_haddr_o) ? src_mem[ahb_haddr_o] : 32'hDEAD_BEEF;
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One copy command: fills the source words, predicts the outcome from the
  // transfer rules, runs it, then compares everything observed.
  // ekind: 0 = clean, 1 = error on read word ek, 2 = error on write word ek.
  task automatic run_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                          input int len, input int w, input int ekind, input int ek,
                          input bit use_pat);
    logic [31:0] sa, da;
    int exp_reads, exp_writes, exp_cyc, exp_nonseq;
    logic exp_err;
    int rd0, wr0, ns0, sv0, cyc, busy_bad, n;
    sa = src & 32'hFFFF_FFFC;
    da = dst & 32'hFFFF_FFFC;
    for (int i = 0; i < len; i++)
      src_mem[sa + 32'(4 * i)] = use_pat ? 32'h1111_1111 * 32'(i + 1) : $urandom;

    if (len == 0) begin
      exp_reads = 0; exp_writes = 0; exp_cyc = 1; exp_err = 1'b0; exp_nonseq = 0;
    end else if (ekind == 1) begin
      exp_reads = ek + 1; exp_writes = ek; exp_err = 1'b1;
      exp_cyc = ek * (4 + 2 * w) + w + 4;
      exp_nonseq = exp_reads + exp_writes;
    end else if (ekind == 2) begin
      exp_reads = ek + 1; exp_writes = ek; exp_err = 1'b1;
      exp_cyc = ek * (4 + 2 * w) + 2 * w + 6;
      exp_nonseq = 2 * ek + 2;
    end else begin
      exp_reads = len; exp_writes = len; exp_err = 1'b0;
      exp_cyc = len * (4 + 2 * w) + 1;
      exp_nonseq = 2 * len;
    end

    @(negedge clk);
    wait_states   = w;
    rd_err_target = (ekind == 1) ? rd_total + ek : -1;
    wr_err_target = (ekind == 2) ? wr_total + ek : -1;
    rd0 = rd_addr_log.size();
    wr0 = wr_addr_log.size();
    ns0 = nonseq_total;
    sv0 = stab_viol;
    chk({name, " ready before accept"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = LEN_W'(len);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;

    cyc = 1;
    busy_bad = 0;
    while (done !== 1'b1 && cyc < 300) begin
      if (busy !== 1'b1 || cmd_ready !== 1'b0) busy_bad++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, " done seen"}, 32'(done), 32'd1);
    chk({name, " done cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({name, " err"}, 32'(err), 32'(exp_err));
    chk({name, " busy at done"}, 32'(busy), 32'd1);
    chk({name, " busy/ready during"}, 32'(busy_bad), 32'd0);
    @(posedge clk);
    #1;
    chk({name, " done one cycle"}, 32'(done), 32'd0);
    chk({name, " idle after"}, {30'd0, busy, cmd_ready}, 32'd1);

    chk({name, " reads"}, 32'(rd_addr_log.size() - rd0), 32'(exp_reads));
    chk({name, " writes"}, 32'(wr_addr_log.size() - wr0), 32'(exp_writes));
    chk({name, " nonseq"}, 32'(nonseq_total - ns0), 32'(exp_nonseq));
    chk({name, " stall stable"}, 32'(stab_viol - sv0), 32'd0);
    n = rd_addr_log.size() - rd0;
    if (n > exp_reads) n = exp_reads;
    for (int i = 0; i < n; i++)
      chk({name, " rd addr"}, rd_addr_log[rd0 + i], sa + 32'(4 * i));
    n = wr_addr_log.size() - wr0;
    if (n > exp_writes) n = exp_writes;
    for (int i = 0; i < n; i++) begin
      chk({name, " wr addr"}, wr_addr_log[wr0 + i], da + 32'(4 * i));
      chk({name, " wr data"}, wr_data_log[wr0 + i], src_mem[sa + 32'(4 * i)]);
    end
    $display("copy %s: src=%h dst=%h len=%0d waits=%0d done@%0d err=%0b", name, src, dst, len, w, cyc, err);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({name, " busy"}, 32'(busy), 32'd0);
    chk({name, " done"}, 32'(done), 32'd0);
    chk({name, " err"}, 32'(err), 32'd0);
    chk({name, " htrans"}, 32'(ahb_htrans_o), 32'd0);
    chk({name, " haddr"}, ahb_haddr_o, 32'd0);
    chk({name, " hwrite"}, 32'(ahb_hwrite_o), 32'd0);
    chk({name, " hwdata"}, ahb_hwdata_o, 32'd0);
  endtask

  initial begin
    int cyc, done_seen, len, w, mode;
    logic [31:0] rs, rdst;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("hsize", 32'(ahb_hsize_o), 32'h2);
    chk("hburst", 32'(ahb_hburst_o), 32'h0);
    chk("hprot", 32'(ahb_hprot_o), 32'h3);
    chk("hmastlock", 32'(ahb_hmastlock_o), 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed copies
    run_copy("basic3", 32'h0000_0100, 32'h0000_0200, 3, 0, 0, 0, 1'b1);
    run_copy("wait2", 32'h0000_0100, 32'h0000_0300, 3, 2, 0, 0, 1'b1);
    run_copy("len0", 32'h0000_0400, 32'h0000_0500, 0, 0, 0, 0, 1'b0);
    run_copy("rderr", 32'h0000_0600, 32'h0000_0700, 3, 0, 1, 1, 1'b0);
    run_copy("wrerr", 32'h0000_0800, 32'h0000_0900, 3, 1, 2, 1, 1'b0);
    run_copy("wrap", 32'hFFFF_FFFF, 32'h0000_1002, 2, 0, 0, 0, 1'b0);

    // Reset during WR_ADDR of the first word
    @(negedge clk);
    wait_states   = 0;
    rd_err_target = -1;
    wr_err_target = -1;
    src_mem[32'h0000_3000] = 32'hCAFE_0001;
    src_mem[32'h0000_3004] = 32'hCAFE_0002;
    cmd_valid = 1'b1;
    cmd_src   = 32'h0000_3000;
    cmd_dst   = 32'h0000_4000;
    cmd_len   = LEN_W'(2);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (!(ahb_htrans_o == 2'b10 && ahb_hwrite_o == 1'b1) && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rst_mid reached WR_ADDR", 32'(ahb_hwrite_o), 32'd1);
    resetn = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    done_seen = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    chk("rst_mid no done", 32'(done_seen), 32'd0);
    chk("rst_mid ready", 32'(cmd_ready), 32'd1);
    $display("reset mid-transfer: done pulses=%0d", done_seen);
    run_copy("after_rst", 32'h0000_3000, 32'h0000_4000, 2, 0, 0, 0, 1'b0);

    // Randomized commands
    for (int t = 0; t < 10; t++) begin
      len  = $urandom_range(1, 6);
      w    = $urandom_range(0, 2);
      mode = $urandom_range(0, 3);
      rs   = 32'h1000_0000 + ($urandom & 32'h0000_FFFF);
      rdst = 32'h2000_0000 + ($urandom & 32'h0000_FFFF);
      run_copy("rand", rs, rdst, len, w, (mode >= 2) ? mode - 1 : 0,
               $urandom_range(0, len - 1), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
